// File: rtl/bcd_seg7_scan.sv
// bcd_seg7_scan: multiplexed 7-segment driver with shadowed BCD capture, frame-aligned updates and leading-zero blanking
module bcd_seg7_scan #(
   parameter int DIGITS     = 3,
   parameter int DIV        = 1000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   bcd_in,
   input  logic                  load,
   input  logic                  blank_lz,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     an,
   output logic                  upd,
   output logic                  frame_done
);
   localparam int PW = $clog2(DIV);
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

   logic [4*DIGITS-1:0] shadow_q, shadow_d, disp_q, disp_d;
   logic                pending_q, pending_d, upd_q, upd_d;
   logic [PW-1:0]       presc_q, presc_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic                tick, z, sel_blk, on;
   logic [3:0]          nib;
   logic [6:0]          seg_a;
   logic [DIGITS-1:0]   an_a;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0: decode = 7'h3F;
         4'd1: decode = 7'h06;
         4'd2: decode = 7'h5B;
         4'd3: decode = 7'h4F;
         4'd4: decode = 7'h66;
         4'd5: decode = 7'h6D;
         4'd6: decode = 7'h7D;
         4'd7: decode = 7'h07;
         4'd8: decode = 7'h7F;
         4'd9: decode = 7'h6F;
         default: decode = 7'h79;
      endcase
   endfunction

   always_comb begin
      tick       = presc_q == PW'(DIV - 1);
      frame_done = tick && idx_q == IW'(DIGITS - 1);
      presc_d    = tick ? '0 : presc_q + 1'b1;
      idx_d      = tick ? (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1) : idx_q;
      shadow_d   = load ? bcd_in : shadow_q;
      pending_d  = load || (pending_q && !frame_done);
      upd_d      = frame_done && pending_q;
      disp_d     = upd_d ? shadow_q : disp_q;
      // walk from the top digit so z tracks "this digit and all above are zero"
      z          = 1'b1;
      nib        = '0;
      sel_blk    = 1'b0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         z = z && disp_q[4*k +: 4] == 4'd0;
         if (idx_q == IW'(k)) begin
            nib     = disp_q[4*k +: 4];
            sel_blk = blank_lz && z && k != 0;
         end
      end
      on    = presc_q != '0 && !sel_blk;
      seg_a = on ? decode(nib) : '0;
      an_a  = on ? DIGITS'(1) << idx_q : '0;
      seg   = ACTIVE_LOW != 0 ? ~seg_a : seg_a;
      an    = ACTIVE_LOW != 0 ? ~an_a : an_a;
      upd   = upd_q;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         shadow_q  <= '0;
         disp_q    <= '0;
         pending_q <= 1'b0;
         presc_q   <= '0;
         idx_q     <= '0;
         upd_q     <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         disp_q    <= disp_d;
         pending_q <= pending_d;
         presc_q   <= presc_d;
         idx_q     <= idx_d;
         upd_q     <= upd_d;
      end
endmodule

// File: tb/tb_bcd_seg7_scan.sv
// tb_bcd_seg7_scan: directed frame-by-frame checks of scan timing, capture, blanking and reset
module tb_bcd_seg7_scan;
   logic        clk = 1'b0, rst, load, blank_lz;
   logic [11:0] bcd_in;
   logic [6:0]  seg;
   logic [2:0]  an;
   logic        upd, frame_done;
   int          n_tests = 0, n_fail = 0;

   typedef struct {
      logic [11:0] bcd;
      logic        blz;
      logic [20:0] seg;
      logic [8:0]  an;
   } vec_t;

   vec_t vecs[8];
   vec_t vz, v222, v456, v777, v888;

   bcd_seg7_scan #(.DIGITS(3), .DIV(4), .ACTIVE_LOW(1)) dut (
      .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load), .blank_lz(blank_lz),
      .seg(seg), .an(an), .upd(upd), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         chk("idle_upd", 32'(upd), 32'h0);
         step();
      end
   endtask

   task automatic check_frame(input vec_t v, input logic upd0);
      for (int c = 0; c < 12; c++) begin
         int s, p;
         s = c / 4;
         p = c % 4;
         chk($sformatf("seg bcd=%h c=%0d", v.bcd, c), 32'(seg), p == 0 ? 32'h7F : 32'(v.seg[s*7 +: 7]));
         chk($sformatf("an bcd=%h c=%0d", v.bcd, c), 32'(an), p == 0 ? 32'h7 : 32'(v.an[s*3 +: 3]));
         chk($sformatf("frame_done c=%0d", c), 32'(frame_done), c == 11 ? 32'h1 : 32'h0);
         chk($sformatf("upd bcd=%h c=%0d", v.bcd, c), 32'(upd), c == 0 ? 32'(upd0) : 32'h0);
         step();
      end
   endtask

   task automatic load_now(input logic [11:0] b);
      bcd_in = b;
      load   = 1'b1;
      step();
      load   = 1'b0;
   endtask

   initial begin
      vecs[0] = '{12'h123, 1'b0, {7'h79, 7'h24, 7'h30}, {3'b011, 3'b101, 3'b110}};
      vecs[1] = '{12'h005, 1'b1, {7'h7F, 7'h7F, 7'h12}, {3'b111, 3'b111, 3'b110}};
      vecs[2] = '{12'h005, 1'b0, {7'h40, 7'h40, 7'h12}, {3'b011, 3'b101, 3'b110}};
      vecs[3] = '{12'h000, 1'b1, {7'h7F, 7'h7F, 7'h40}, {3'b111, 3'b111, 3'b110}};
      vecs[4] = '{12'h050, 1'b1, {7'h7F, 7'h12, 7'h40}, {3'b111, 3'b101, 3'b110}};
      vecs[5] = '{12'h0A7, 1'b1, {7'h7F, 7'h06, 7'h78}, {3'b111, 3'b101, 3'b110}};
      vecs[6] = '{12'h9F8, 1'b1, {7'h10, 7'h06, 7'h00}, {3'b011, 3'b101, 3'b110}};
      vecs[7] = '{12'h406, 1'b1, {7'h19, 7'h40, 7'h02}, {3'b011, 3'b101, 3'b110}};
      vz      = '{12'h000, 1'b0, {7'h40, 7'h40, 7'h40}, {3'b011, 3'b101, 3'b110}};
      v222    = '{12'h222, 1'b0, {7'h24, 7'h24, 7'h24}, {3'b011, 3'b101, 3'b110}};
      v456    = '{12'h456, 1'b0, {7'h19, 7'h12, 7'h02}, {3'b011, 3'b101, 3'b110}};
      v777    = '{12'h777, 1'b0, {7'h78, 7'h78, 7'h78}, {3'b011, 3'b101, 3'b110}};
      v888    = '{12'h888, 1'b0, {7'h00, 7'h00, 7'h00}, {3'b011, 3'b101, 3'b110}};

      rst = 1'b1; load = 1'b0; bcd_in = '0; blank_lz = 1'b0;
      #1;
      chk("reset_an", 32'(an), 32'h7);
      chk("reset_seg", 32'(seg), 32'h7F);
      chk("reset_upd", 32'(upd), 32'h0);
      step();
      step();
      rst = 1'b0;
      step();
      step();
      step();
      step();
      step();
      step();
      chk("pre_rst_an", 32'(an), 32'h5);
      chk("pre_rst_seg", 32'(seg), 32'h40);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_an", 32'(an), 32'h7);
      chk("async_rst_seg", 32'(seg), 32'h7F);
      chk("async_rst_upd", 32'(upd), 32'h0);
      chk("async_rst_fd", 32'(frame_done), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      check_frame(vz, 1'b0);
      check_frame(vz, 1'b0);

      // mid-frame load: old digits stay up until the frame boundary
      idle(5);
      load_now(12'h123);
      for (int c = 6; c < 12; c++) begin
         chk($sformatf("mid_upd c=%0d", c), 32'(upd), 32'h0);
         if (c % 4 != 0) chk($sformatf("mid_seg c=%0d", c), 32'(seg), 32'h40);
         step();
      end
      check_frame(vecs[0], 1'b1);

      for (int i = 0; i < 8; i++) begin
         blank_lz = vecs[i].blz;
         load_now(vecs[i].bcd);
         idle(11);
         check_frame(vecs[i], 1'b1);
      end

      blank_lz = 1'b0;
      idle(2);
      load_now(12'h111);
      idle(4);
      load_now(12'h222);
      idle(4);
      check_frame(v222, 1'b1);

      // load coinciding with frame_done while nothing is pending
      idle(11);
      chk("coinc_fd", 32'(frame_done), 32'h1);
      load_now(12'h456);
      check_frame(v222, 1'b0);
      check_frame(v456, 1'b1);

      // load at frame_done with an older value already pending
      idle(3);
      load_now(12'h777);
      idle(7);
      chk("coinc2_fd", 32'(frame_done), 32'h1);
      load_now(12'h888);
      check_frame(v777, 1'b1);
      check_frame(v888, 1'b1);

      load_now(12'h999);
      idle(4);
      chk("midscan_an", 32'(an), 32'h5);
      #2 rst = 1'b1;
      #1;
      chk("midscan_rst_an", 32'(an), 32'h7);
      chk("midscan_rst_seg", 32'(seg), 32'h7F);
      @(negedge clk);
      rst = 1'b0;
      check_frame(vz, 1'b0);
      check_frame(vz, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
